// File: rtl/gp_counter_if.sv
// Signal bundle between gp_counter_core and the logic that controls and reads it.
// presc_i exists only when GP_COUNTER_PRESCALER_EN is defined.
interface gp_counter_if #(
    parameter int WIDTH = 16
);
    logic             enable_i;
    logic             trigger_i;
    logic             capture_i;
    logic             dir_i;
    logic             mode_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] period_i;
`ifdef GP_COUNTER_PRESCALER_EN
    logic [7:0]       presc_i;
`endif
    logic [WIDTH-1:0] count_o;
    logic             running_o;
    logic             tc_o;
    logic [WIDTH-1:0] capture_val_o;
    logic             capture_valid_o;
    logic             capture_ack_i;
    logic             capture_ovr_o;

    modport master (
        output enable_i, trigger_i, capture_i, dir_i, mode_i, load_i,
        output load_val_i, period_i, capture_ack_i,
`ifdef GP_COUNTER_PRESCALER_EN
        output presc_i,
`endif
        input  count_o, running_o, tc_o, capture_val_o, capture_valid_o, capture_ovr_o
    );

    modport slave (
        input  enable_i, trigger_i, capture_i, dir_i, mode_i, load_i,
        input  load_val_i, period_i, capture_ack_i,
`ifdef GP_COUNTER_PRESCALER_EN
        input  presc_i,
`endif
        output count_o, running_o, tc_o, capture_val_o, capture_valid_o, capture_ovr_o
    );
endinterface

// File: rtl/gp_counter_core.sv
// Up/down counter with programmable period, one-shot mode, terminal-count pulse and
// snapshot capture with valid/ack/overrun. Optional prescaler: GP_COUNTER_PRESCALER_EN.
module gp_counter_core #(
    parameter int WIDTH = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    gp_counter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic             tc;
    logic [WIDTH-1:0] cap_val;
    logic             cap_valid;
    logic             cap_ovr;
    logic             accept;
    logic             advance;
    logic             at_term;

    // An accepted trigger: running, still enabled, and not overridden by a load.
    assign accept  = (state == RUN) && bus.enable_i && bus.trigger_i && !bus.load_i;
    assign at_term = bus.dir_i ? (count == '0) : (count == bus.period_i);

`ifdef GP_COUNTER_PRESCALER_EN
    logic [7:0] presc_cnt;

    assign advance = accept && (presc_cnt == bus.presc_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_cnt <= '0;
        end else if (bus.load_i || state != RUN || state_next != RUN) begin
            presc_cnt <= '0;
        end else if (accept) begin
            presc_cnt <= (presc_cnt == bus.presc_i) ? 8'd0 : presc_cnt + 8'd1;
        end
    end
`else
    assign advance = accept;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (bus.load_i) begin
            count_next = bus.load_val_i;
        end else if (advance) begin
            if (!bus.dir_i) begin
                if (at_term) count_next = bus.mode_i ? bus.period_i : '0;
                else         count_next = count + ONE;
            end else begin
                if (at_term) count_next = bus.mode_i ? '0 : bus.period_i;
                else         count_next = count - ONE;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.enable_i) state_next = RUN;
            RUN: begin
                if (!bus.enable_i)                        state_next = IDLE;
                else if (advance && at_term && bus.mode_i) state_next = DONE;
            end
            DONE: begin
                if (!bus.enable_i)   state_next = IDLE;
                else if (bus.load_i) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            count <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            tc    <= advance && at_term;
        end
    end

    // Snapshot takes the pre-update count; an ack in the same cycle frees the slot.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cap_val   <= '0;
            cap_valid <= 1'b0;
            cap_ovr   <= 1'b0;
        end else begin
            if (bus.capture_ack_i) begin
                cap_valid <= 1'b0;
                cap_ovr   <= 1'b0;
            end
            if (bus.capture_i) begin
                if (!cap_valid || bus.capture_ack_i) begin
                    cap_val   <= count;
                    cap_valid <= 1'b1;
                end else begin
                    cap_ovr   <= 1'b1;
                end
            end
        end
    end

    assign bus.count_o         = count;
    assign bus.running_o       = (state == RUN);
    assign bus.tc_o            = tc;
    assign bus.capture_val_o   = cap_val;
    assign bus.capture_valid_o = cap_valid;
    assign bus.capture_ovr_o   = cap_ovr;
endmodule

// File: tb/tb_gp_counter_core.sv
// Directed bench for gp_counter_core; the prescaler step runs only with GP_COUNTER_PRESCALER_EN.
module tb_gp_counter_core;
    localparam int WIDTH = 16;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    gp_counter_if #(.WIDTH(WIDTH)) bus ();

    gp_counter_core #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".count"},   32'(bus.count_o), 0);
        check({tag, ".running"}, 32'(bus.running_o), 0);
        check({tag, ".tc"},      32'(bus.tc_o), 0);
        check({tag, ".cap_val"}, 32'(bus.capture_val_o), 0);
        check({tag, ".valid"},   32'(bus.capture_valid_o), 0);
        check({tag, ".ovr"},     32'(bus.capture_ovr_o), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] up_cnt [5];
        logic             up_tc  [5];
        logic [WIDTH-1:0] dn_cnt [4];
        logic             dn_tc  [4];
        logic             dn_run [4];
        up_cnt = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        up_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        dn_cnt = '{16'd1, 16'd0, 16'd0, 16'd0};
        dn_tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
        dn_run = '{1'b1, 1'b1, 1'b0, 1'b0};

        n_checks = 0;
        n_fail   = 0;
        rstn = 1'b0;
        bus.enable_i = 0; bus.trigger_i = 0; bus.capture_i = 0; bus.dir_i = 0;
        bus.mode_i = 0; bus.load_i = 0; bus.load_val_i = '0; bus.period_i = '0;
        bus.capture_ack_i = 0;
`ifdef GP_COUNTER_PRESCALER_EN
        bus.presc_i = 8'd0;
`endif
        #2;
        check_all_zero("reset");
        tick();
        rstn = 1'b1;
        tick();

        // Free-running up count; the trigger coinciding with enable rising is ignored.
        bus.period_i = 16'd3;
        bus.enable_i = 1;
        bus.trigger_i = 1;
        tick();
        check("enable.running", 32'(bus.running_o), 1);
        check("enable.trig_ignored", 32'(bus.count_o), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("up.count%0d", i), 32'(bus.count_o), 32'(up_cnt[i]));
            check($sformatf("up.tc%0d", i), 32'(bus.tc_o), 32'(up_tc[i]));
        end
        bus.trigger_i = 0;
        tick();
        check("up.tc_idle", 32'(bus.tc_o), 0);

        // Load beats trigger; a count above period keeps counting up.
        bus.load_val_i = 16'd10;
        bus.load_i = 1;
        bus.trigger_i = 1;
        tick();
        check("collide.count", 32'(bus.count_o), 10);
        check("collide.tc", 32'(bus.tc_o), 0);
        bus.load_i = 0;
        tick();
        check("above_period.count", 32'(bus.count_o), 11);
        check("above_period.tc", 32'(bus.tc_o), 0);
        bus.trigger_i = 0;

        // One-shot down count from 2.
        bus.dir_i = 1;
        bus.mode_i = 1;
        bus.load_val_i = 16'd2;
        bus.load_i = 1;
        tick();
        check("dn.load", 32'(bus.count_o), 2);
        bus.load_i = 0;
        bus.trigger_i = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("dn.count%0d", i), 32'(bus.count_o), 32'(dn_cnt[i]));
            check($sformatf("dn.tc%0d", i), 32'(bus.tc_o), 32'(dn_tc[i]));
            check($sformatf("dn.running%0d", i), 32'(bus.running_o), 32'(dn_run[i]));
        end
        bus.trigger_i = 0;
        bus.load_val_i = 16'd5;
        bus.load_i = 1;
        tick();
        check("done_load.running", 32'(bus.running_o), 1);
        check("done_load.count", 32'(bus.count_o), 5);
        bus.load_i = 0;

        // Capture handshake with overrun.
        bus.dir_i = 0;
        bus.mode_i = 0;
        bus.period_i = 16'd100;
        bus.load_val_i = 16'd7;
        bus.load_i = 1;
        tick();
        bus.load_i = 0;
        bus.capture_i = 1;
        tick();
        check("cap1.val", 32'(bus.capture_val_o), 7);
        check("cap1.valid", 32'(bus.capture_valid_o), 1);
        check("cap1.ovr", 32'(bus.capture_ovr_o), 0);
        bus.capture_i = 0;
        bus.load_val_i = 16'd9;
        bus.load_i = 1;
        tick();
        bus.load_i = 0;
        bus.capture_i = 1;
        tick();
        check("cap2.val_kept", 32'(bus.capture_val_o), 7);
        check("cap2.ovr", 32'(bus.capture_ovr_o), 1);
        check("cap2.valid", 32'(bus.capture_valid_o), 1);
        bus.capture_i = 0;
        bus.capture_ack_i = 1;
        tick();
        check("ack.valid", 32'(bus.capture_valid_o), 0);
        check("ack.ovr", 32'(bus.capture_ovr_o), 0);
        bus.capture_ack_i = 0;

        // Capture sees the pre-load count; then capture+ack replaces the snapshot.
        bus.load_val_i = 16'd4;
        bus.load_i = 1;
        bus.capture_i = 1;
        tick();
        check("cap_pre.val", 32'(bus.capture_val_o), 9);
        check("cap_pre.count", 32'(bus.count_o), 4);
        bus.load_i = 0;
        bus.capture_ack_i = 1;
        tick();
        check("capack.val", 32'(bus.capture_val_o), 4);
        check("capack.valid", 32'(bus.capture_valid_o), 1);
        check("capack.ovr", 32'(bus.capture_ovr_o), 0);
        bus.capture_i = 0;
        bus.capture_ack_i = 0;

        // period 0: every trigger is a terminal event, up or down.
        bus.period_i = 16'd0;
        bus.load_val_i = 16'd0;
        bus.load_i = 1;
        tick();
        bus.load_i = 0;
        bus.trigger_i = 1;
        tick();
        check("p0.up.count", 32'(bus.count_o), 0);
        check("p0.up.tc", 32'(bus.tc_o), 1);
        bus.dir_i = 1;
        tick();
        check("p0.dn.count", 32'(bus.count_o), 0);
        check("p0.dn.tc", 32'(bus.tc_o), 1);
        bus.trigger_i = 0;
        bus.dir_i = 0;
        tick();
        check("p0.tc_clear", 32'(bus.tc_o), 0);

        // Disabled: load still works, triggers do not advance.
        bus.enable_i = 0;
        bus.load_val_i = 16'd3;
        bus.load_i = 1;
        tick();
        check("dis.running", 32'(bus.running_o), 0);
        check("dis.load", 32'(bus.count_o), 3);
        bus.load_i = 0;
        bus.trigger_i = 1;
        tick();
        check("dis.hold", 32'(bus.count_o), 3);
        bus.trigger_i = 0;

`ifdef GP_COUNTER_PRESCALER_EN
        bus.enable_i = 1;
        tick();
        bus.presc_i = 8'd2;
        bus.period_i = 16'd100;
        bus.load_val_i = 16'd0;
        bus.load_i = 1;
        tick();
        bus.load_i = 0;
        bus.trigger_i = 1;
        for (int i = 0; i < 9; i++) tick();
        bus.trigger_i = 0;
        tick();
        check("presc.count", 32'(bus.count_o), 3);
        bus.presc_i = 8'd0;
`endif

        // Asynchronous reset with a capture pending and the counter moving.
        bus.enable_i = 1;
        tick();
        bus.capture_i = 1;
        bus.trigger_i = 1;
        tick();
        bus.capture_i = 0;
        tick();
        check("pre_rst.valid", 32'(bus.capture_valid_o), 1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        bus.trigger_i = 0;
        bus.enable_i = 0;
        tick();
        check_all_zero("rst_held");
        rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
